// File: rtl/edge_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_pkg : mode encodings and sizing helpers shared by the edge detector
// Revision : 1.0
// ---------------------------------------------------------------------------
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // A debounce length of zero behaves like one: accept on the first differing cycle.
  function automatic int eff_debounce(input int cycles);
    return (cycles < 1) ? 1 : cycles;
  endfunction

  function automatic int cnt_width(input int cycles);
    return ($clog2(eff_debounce(cycles) + 1) < 1) ? 1 : $clog2(eff_debounce(cycles) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_channel : one input channel - synchroniser, debounce, edge pulses, flag
// Revision     : 1.0
// ---------------------------------------------------------------------------
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       evt,
  output logic       flag
);

  localparam int SS     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int DB_EFF = eff_debounce(DEBOUNCE_CYCLES);
  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_EFF - 1);

  logic [SS-1:0]    sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             flag_q;
  logic             synced;
  logic             differs;
  logic             toggle;
  logic             evt_c;

  assign synced  = sync_q[SS-1];
  assign differs = (synced != level_q);
  assign toggle  = differs && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SS-2:0], signal};
    end
  end

  // Counter runs only while the synchronised input disagrees with the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= toggle && !level_q;
      fall_q <= toggle && level_q;
      if (!differs || toggle) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (toggle) begin
        level_q <= ~level_q;
      end
    end
  end

  always_comb begin
    evt_c = 1'b0;
    unique case (mode_e'(mode))
      MODE_NONE: evt_c = 1'b0;
      MODE_RISE: evt_c = rise_q;
      MODE_FALL: evt_c = fall_q;
      MODE_BOTH: evt_c = rise_q | fall_q;
      default:   evt_c = 1'b0;
    endcase
  end

  // A new event outranks a clear arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else if (evt_c) begin
      flag_q <= 1'b1;
    end else if (clr) begin
      flag_q <= 1'b0;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign evt   = evt_c;
  assign flag  = flag_q;

endmodule
`default_nettype wire

// File: rtl/edge_detector_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_detector_array : CHANNELS independent debounced edge detectors + IRQ
// Revision            : 1.0
// ---------------------------------------------------------------------------
module edge_detector_array
  import edge_pkg::*;
#(
  parameter int CHANNELS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   signal_i,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   clr_i,
  output logic [CHANNELS-1:0]   level_o,
  output logic [CHANNELS-1:0]   rise_o,
  output logic [CHANNELS-1:0]   fall_o,
  output logic [CHANNELS-1:0]   event_o,
  output logic [CHANNELS-1:0]   flag_o,
  output logic                  irq_o
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
    edge_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .clk    (clk),
      .rst_n  (rst_n),
      .signal (signal_i[c]),
      .mode   (mode_i[2*c +: 2]),
      .clr    (clr_i[c]),
      .level  (level_o[c]),
      .rise   (rise_o[c]),
      .fall   (fall_o[c]),
      .evt    (event_o[c]),
      .flag   (flag_o[c])
    );
  end

  assign irq_o = |flag_o;

endmodule
`default_nettype wire

// File: tb/tb_edge_detector_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_edge_detector_array : vector table + scoreboard bench, 4 ch, 2 sync, 3 db
// Revision               : 1.0
// ---------------------------------------------------------------------------
module tb_edge_detector_array;
  import edge_pkg::*;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   signal_i;
  logic [2*CH-1:0] mode_i;
  logic [CH-1:0]   clr_i;
  logic [CH-1:0]   level_o;
  logic [CH-1:0]   rise_o;
  logic [CH-1:0]   fall_o;
  logic [CH-1:0]   event_o;
  logic [CH-1:0]   flag_o;
  logic            irq_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] evt;
    logic [3:0] flag;
    logic       irq;
  } exp_t;

  typedef struct {
    logic [3:0] sig;
    logic [7:0] mode;
    logic [3:0] clr;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t vt[0:23];

  edge_detector_array #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .signal_i (signal_i),
    .mode_i   (mode_i),
    .clr_i    (clr_i),
    .level_o  (level_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .event_o  (event_o),
    .flag_o   (flag_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk_exp(input logic [3:0] lvl, input logic [3:0] rise,
                                  input logic [3:0] fall, input logic [3:0] evt,
                                  input logic [3:0] flag);
    exp_t e;
    e.lvl  = lvl;
    e.rise = rise;
    e.fall = fall;
    e.evt  = evt;
    e.flag = flag;
    e.irq  = |flag;
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] sig, input logic [7:0] mode,
                              input logic [3:0] clr, input logic [3:0] lvl,
                              input logic [3:0] rise, input logic [3:0] fall,
                              input logic [3:0] evt, input logic [3:0] flag);
    vec_t v;
    v.sig  = sig;
    v.mode = mode;
    v.clr  = clr;
    v.e    = mk_exp(lvl, rise, fall, evt, flag);
    return v;
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got nothing, required an entry", name);
    end else begin
      e = sb.pop_front();
      cmp({name, ".level"}, level_o, e.lvl);
      cmp({name, ".rise"},  rise_o,  e.rise);
      cmp({name, ".fall"},  fall_o,  e.fall);
      cmp({name, ".event"}, event_o, e.evt);
      cmp({name, ".flag"},  flag_o,  e.flag);
      cmp({name, ".irq"},   {3'b000, irq_o}, {3'b000, e.irq});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ma;
    logic [7:0] mb;
    ma = {MODE_NONE, MODE_BOTH, MODE_FALL, MODE_RISE};
    mb = {MODE_BOTH, MODE_BOTH, MODE_FALL, MODE_NONE};

    //           sig    mode clr    lvl    rise   fall   evt    flag
    vt[0]  = mk(4'h3, ma, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vt[1]  = mk(4'hB, ma, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vt[2]  = mk(4'hD, ma, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vt[3]  = mk(4'hD, ma, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    vt[4]  = mk(4'hD, ma, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0);
    vt[5]  = mk(4'hD, ma, 4'h0, 4'h9, 4'h8, 4'h0, 4'h0, 4'h1);
    vt[6]  = mk(4'hF, ma, 4'h0, 4'hD, 4'h4, 4'h0, 4'h4, 4'h1);
    vt[7]  = mk(4'hF, ma, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h5);
    vt[8]  = mk(4'hF, mb, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h5);
    vt[9]  = mk(4'h7, mb, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h5);
    vt[10] = mk(4'h7, mb, 4'h0, 4'hF, 4'h2, 4'h0, 4'h0, 4'h5);
    vt[11] = mk(4'h7, mb, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h5);
    vt[12] = mk(4'h3, mb, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h5);
    vt[13] = mk(4'h3, mb, 4'h0, 4'h7, 4'h0, 4'h8, 4'h8, 4'h5);
    vt[14] = mk(4'h1, mb, 4'h0, 4'h7, 4'h0, 4'h0, 4'h0, 4'hD);
    vt[15] = mk(4'h1, mb, 4'h0, 4'h7, 4'h0, 4'h0, 4'h0, 4'hD);
    vt[16] = mk(4'h1, mb, 4'h0, 4'h3, 4'h0, 4'h4, 4'h4, 4'hD);
    vt[17] = mk(4'h1, mb, 4'h4, 4'h3, 4'h0, 4'h0, 4'h0, 4'hD);
    vt[18] = mk(4'h1, mb, 4'h0, 4'h1, 4'h0, 4'h2, 4'h2, 4'hD);
    vt[19] = mk(4'h1, mb, 4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'hB);
    vt[20] = mk(4'h1, mb, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'hB);
    vt[21] = mk(4'h1, mb, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h9);
    vt[22] = mk(4'h1, mb, 4'h9, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    vt[23] = mk(4'h1, mb, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);

    rst_n    = 1'b0;
    signal_i = '0;
    mode_i   = '0;
    clr_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk_exp(4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    check_outputs("reset");

    // Main table: release reset and apply vector 0 before cycle 0.
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) rst_n = 1'b1;
      signal_i = vt[k].sig;
      mode_i   = vt[k].mode;
      clr_i    = vt[k].clr;
      sb.push_back(vt[k].e);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", k));
    end

    // Reset two cycles into a ch3 rise, then input low after release.
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      signal_i = 4'h9;
      mode_i   = 8'h00;
      clr_i    = 4'h0;
      sb.push_back(mk_exp(4'h1, 4'h0, 4'h0, 4'h0, 4'h0));
      @(posedge clk);
      #1;
      check_outputs($sformatf("pre_rst%0d", j));
    end
    @(negedge clk);
    mode_i = 8'hFF;
    rst_n  = 1'b0;
    #1;
    sb.push_back(mk_exp(4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    check_outputs("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    signal_i = 4'h0;
    rst_n    = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      sb.push_back(mk_exp(4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
      @(posedge clk);
      #1;
      check_outputs($sformatf("post_rst%0d", j));
    end

    // Inputs held high through reset, rising mode on every channel.
    @(negedge clk);
    rst_n    = 1'b0;
    signal_i = 4'hF;
    mode_i   = {MODE_RISE, MODE_RISE, MODE_RISE, MODE_RISE};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      sb.push_back(mk_exp((k >= 4) ? 4'hF : 4'h0,
                          (k == 4) ? 4'hF : 4'h0,
                          4'h0,
                          (k == 4) ? 4'hF : 4'h0,
                          (k >= 5) ? 4'hF : 4'h0));
      @(posedge clk);
      #1;
      check_outputs($sformatf("held%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
